// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with registered sync, data-enable,
// coordinate and start-of-frame outputs, advancing one pixel per enabled clk edge.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int H_W     = $clog2(H_TOTAL),
  localparam int V_W     = $clog2(V_TOTAL)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clk_en,
  output logic           hs,
  output logic           vs,
  output logic           de,
  output logic [H_W-1:0] x,
  output logic [V_W-1:0] y,
  output logic           sof
);

  localparam logic [H_W-1:0] H_MAX = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_MAX = V_W'(V_TOTAL - 1);

  // Decode bounds carry one extra bit: with a zero back porch the sync end
  // equals TOTAL, which may not fit in the counter width.
  localparam logic [H_W:0] H_ACT_E  = (H_W + 1)'(H_ACTIVE);
  localparam logic [H_W:0] HS_BEG   = (H_W + 1)'(H_ACTIVE + H_FP);
  localparam logic [H_W:0] HS_END   = (H_W + 1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W:0] V_ACT_E  = (V_W + 1)'(V_ACTIVE);
  localparam logic [V_W:0] VS_BEG   = (V_W + 1)'(V_ACTIVE + V_FP);
  localparam logic [V_W:0] VS_END   = (V_W + 1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic         HS_ACT   = (HS_POL != 0);
  localparam logic         VS_ACT   = (VS_POL != 0);

  logic [H_W-1:0] h_cnt, h_nxt;
  logic [V_W-1:0] v_cnt, v_nxt;
  logic           hs_nxt, vs_nxt, de_nxt, sof_nxt;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    h_nxt = h_cnt + H_W'(1);
    v_nxt = v_cnt;
    if (h_cnt == H_MAX) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_MAX) ? '0 : v_cnt + V_W'(1);
    end
    de_nxt  = ({1'b0, h_nxt} < H_ACT_E) && ({1'b0, v_nxt} < V_ACT_E);
    hs_nxt  = ({1'b0, h_nxt} >= HS_BEG) && ({1'b0, h_nxt} < HS_END) ? HS_ACT : !HS_ACT;
    vs_nxt  = ({1'b0, v_nxt} >= VS_BEG) && ({1'b0, v_nxt} < VS_END) ? VS_ACT : !VS_ACT;
    sof_nxt = (h_nxt == '0) && (v_nxt == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= H_MAX;
      v_cnt <= V_MAX;
      hs    <= !HS_ACT;
      vs    <= !VS_ACT;
      de    <= 1'b0;
      sof   <= 1'b0;
    end else if (clk_en) begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      hs    <= hs_nxt;
      vs    <= vs_nxt;
      de    <= de_nxt;
      sof   <= sof_nxt;
    end else begin
      sof   <= 1'b0;
    end
  end

  assign x = h_cnt;
  assign y = v_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: small 8x6 raster at both sync polarities plus the default
// 640x480 line, sharing clk, rst and clk_en.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic clk_en;

  logic       s_hs, s_vs, s_de, s_sof;
  logic [2:0] s_x, s_y;
  logic       p_hs, p_vs, p_de, p_sof;
  logic [2:0] p_x, p_y;
  logic       d_hs, d_vs, d_de, d_sof;
  logic [9:0] d_x, d_y;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0)
  ) u_small (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .hs(s_hs), .vs(s_vs), .de(s_de), .x(s_x), .y(s_y), .sof(s_sof)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1)
  ) u_pol (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .hs(p_hs), .vs(p_vs), .de(p_de), .x(p_x), .y(p_y), .sof(p_sof)
  );

  vga_timing_gen u_dflt (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .hs(d_hs), .vs(d_vs), .de(d_de), .x(d_x), .y(d_y), .sof(d_sof)
  );

  typedef struct {
    logic en;
    int   x;
    int   y;
    logic de;
    logic hs_on;
    logic vs_on;
    logic sof;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Checks both small instances; hs_on/vs_on mean "sync active".
  task automatic check_small(input string tag, input int ex, input int ey,
                             input logic ede, input logic ehs, input logic evs,
                             input logic esof);
    check({tag, ".x"},     int'(s_x),   ex);
    check({tag, ".y"},     int'(s_y),   ey);
    check({tag, ".de"},    int'(s_de),  int'(ede));
    check({tag, ".hs"},    int'(s_hs),  int'(!ehs));
    check({tag, ".vs"},    int'(s_vs),  int'(!evs));
    check({tag, ".sof"},   int'(s_sof), int'(esof));
    check({tag, ".p_hs"},  int'(p_hs),  int'(ehs));
    check({tag, ".p_vs"},  int'(p_vs),  int'(evs));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    clk_en = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int cnt;
    rst    = 1'b0;
    clk_en = 1'b0;

    vecs[0]  = '{1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 3, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 5, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 6, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 7, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 0, 1, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_small("reset", 7, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.d_x", int'(d_x), 799);
    check("reset.d_y", int'(d_y), 524);
    @(negedge clk);
    rst = 1'b1;

    // First line, including a two-cycle clk_en stall
    for (int i = 0; i < 11; i++) begin
      clk_en = vecs[i].en;
      step();
      check_small($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].de,
                  vecs[i].hs_on, vecs[i].vs_on, vecs[i].sof);
    end

    // Vertical sync: (0,1) -> (7,3) -> (0,4) asserts -> (0,5) deasserts
    run(23);
    check_small("pre_vs", 7, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    run(1);
    check_small("vs_on", 0, 4, 1'b0, 1'b0, 1'b1, 1'b0);
    run(5);
    check_small("vs_mid", 5, 4, 1'b0, 1'b1, 1'b1, 1'b0);
    run(3);
    check_small("vs_off", 0, 5, 1'b0, 1'b0, 1'b0, 1'b0);

    // Enter (0,0) then stall: sof lasts exactly one clk
    run(8);
    check_small("sof_in", 0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    clk_en = 1'b0;
    step();
    check_small("sof_hold1", 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check_small("sof_hold2", 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Frame period of the small raster
    clk_en = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (s_sof) begin
        cnt = i;
        break;
      end
    end
    check("sof_period", cnt, 48);

    // Asynchronous reset between edges at (2,1)
    run(10);
    check("pre_rst.x", int'(s_x), 2);
    check("pre_rst.y", int'(s_y), 1);
    #2;
    rst = 1'b0;
    #1;
    check_small("async_rst", 7, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    check("async_rst.d_x", int'(d_x), 799);
    @(negedge clk);
    rst = 1'b1;
    run(1);
    check_small("restart", 0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("restart.d_sof", int'(d_sof), 1);
    check("restart.d_de", int'(d_de), 1);

    // Default 640x480 line: de drops at 640, hs low 656..751, wrap after 799
    run(639);
    check("d639.x", int'(d_x), 639);
    check("d639.de", int'(d_de), 1);
    run(1);
    check("d640.de", int'(d_de), 0);
    check("d655.hs_pre", int'(d_hs), 1);
    run(16);
    check("d656.x", int'(d_x), 656);
    check("d656.hs", int'(d_hs), 0);
    run(95);
    check("d751.hs", int'(d_hs), 0);
    run(1);
    check("d752.hs", int'(d_hs), 1);
    run(47);
    check("d799.x", int'(d_x), 799);
    check("d799.y", int'(d_y), 0);
    run(1);
    check("dwrap.x", int'(d_x), 0);
    check("dwrap.y", int'(d_y), 1);
    check("dwrap.de", int'(d_de), 1);
    check("dwrap.vs", int'(d_vs), 1);
    check("dwrap.sof", int'(d_sof), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
